pix_capture: RTL and testbench

PIX_CAPTURE -- requirements
Module: pix_capture

---
 rtl/pix_capture_pkg.sv | 34 +++
 rtl/pix_capture_fifo.sv | 46 ++++
 rtl/pix_capture.sv | 145 ++++++++++++++
 tb/tb_pix_capture.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_capture_pkg.sv
// pix_capture_pkg: 640x480 timing defaults, capture FSM states, colour expansion.
// Build option PIX_CAPTURE_REPLICATE_EN: fill colour LSBs by bit replication.
package pix_capture_pkg;

    localparam int H_PERIOD_640 = 800;
    localparam int V_PERIOD_480 = 525;
    localparam int H_START_640  = 160;
    localparam int V_START_480  = 45;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        DRAIN
    } state_t;

    // c holds the colour MSB-aligned; cb is the number of valid colour bits
    function automatic logic [7:0] msb_expand(
        input logic [7:0] c,
        input int         cb
    );
        logic [7:0] r;
`ifdef PIX_CAPTURE_REPLICATE_EN
        r = c;
        for (int i = 0; i < 8; i++) begin
            r[7 - i] = c[7 - (i % cb)];
        end
`else
        r = c & ~(8'hFF >> cb);
`endif
        return r;
    endfunction

endpackage

// File: rtl/pix_capture_fifo.sv
// pix_capture_fifo: synchronous FIFO holding packed RGB pixels.
// A write into a full FIFO is accepted when a read frees the slot.
module pix_capture_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW])
                  && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_rd   = rd_i && !empty_o;
    assign do_wr   = wr_i && (!full_o || do_rd);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/pix_capture.sv
// pix_capture: grabs NFRAMES video frames and streams them as R,G,B bytes.
// Build option PIX_CAPTURE_REPLICATE_EN: colour LSBs replicated, else zero.
module pix_capture
    import pix_capture_pkg::*;
#(
    parameter int HPERIOD = H_PERIOD_640,
    parameter int VPERIOD = V_PERIOD_480,
    parameter int HSTART  = H_START_640,
    parameter int VSTART  = V_START_480,
    parameter int CBITS   = 4,
    parameter int NFRAMES = 1,
    parameter int DEPTH   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PEN,
    input  logic [9:0]       HCNT,
    input  logic [9:0]       VCNT,
    input  logic [CBITS-1:0] VGA_R,
    input  logic [CBITS-1:0] VGA_G,
    input  logic [CBITS-1:0] VGA_B,
    input  logic             START,
    output logic [7:0]       OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVERFLOW
);

    localparam int         PW      = 3 * CBITS;
    localparam logic [9:0] H_FIRST = 10'(HSTART);
    localparam logic [9:0] V_FIRST = 10'(VSTART);
    localparam logic [9:0] H_LAST  = 10'(HPERIOD - 1);
    localparam logic [9:0] V_LAST  = 10'(VPERIOD - 1);
    localparam logic [7:0] NF      = 8'(NFRAMES);

    state_t        state_q;
    logic [7:0]    frame_q;
    logic [7:0]    frame_d;
    logic          ovf_q;
    logic [PW-1:0] pix_q;
    logic [1:0]    idx_q;
    logic          valid_q;
    logic [7:0]    data_q;

    logic [PW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          sof;
    logic          fend;
    logic          active;
    logic          push;
    logic          pop;
    logic          fire;
    logic          last;
    logic          done_w;

    function automatic logic [7:0] to8(input logic [CBITS-1:0] c);
        return msb_expand(8'(c) << (8 - CBITS), CBITS);
    endfunction

    assign sof    = PEN && (HCNT == '0) && (VCNT == '0);
    assign fend   = PEN && (HCNT == H_LAST) && (VCNT == V_LAST);
    assign active = PEN && (HCNT >= H_FIRST) && (VCNT >= V_FIRST);
    assign push   = (state_q == CAPTURE) && active;
    assign fire   = valid_q && OUT_READY;
    assign last   = (idx_q == 2'd2);
    assign pop    = !fifo_empty && (!valid_q || (fire && last));
    assign done_w = (state_q == DRAIN) && fire && last && fifo_empty;
    assign frame_d = frame_q + 8'd1;

    pix_capture_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .wr_i    (push),
        .wdata_i ({VGA_R, VGA_G, VGA_B}),
        .rd_i    (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            frame_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (START) begin
                        state_q <= WAIT_SOF;
                        frame_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                WAIT_SOF: begin
                    if (sof) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (fend) begin
                        frame_q <= frame_d;
                        if (frame_d == NF) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // second term covers a drain with nothing left to send
                    if (done_w || (fifo_empty && !valid_q)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pix_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (pop) begin
            pix_q   <= fifo_rdata;
            idx_q   <= 2'd0;
            valid_q <= 1'b1;
            data_q  <= to8(fifo_rdata[2*CBITS +: CBITS]);
        end else if (fire) begin
            if (last) valid_q <= 1'b0;
            idx_q  <= idx_q + 2'd1;
            data_q <= (idx_q == 2'd0) ? to8(pix_q[CBITS +: CBITS])
                                      : to8(pix_q[0 +: CBITS]);
        end
    end

    assign OUT_VALID = valid_q && !RST;
    assign OUT_DATA  = RST ? 8'd0 : data_q;
    assign BUSY      = (state_q != IDLE) && !RST;
    assign DONE      = done_w && !RST;
    assign OVERFLOW  = ovf_q && !RST;

endmodule

// File: tb/tb_pix_capture.sv
// tb_pix_capture: scoreboard bench on a reduced 16x10 raster with
// one NFRAMES=1 and one NFRAMES=2 instance fed by the same stimulus.
`timescale 1ns/1ps
module tb_pix_capture;

    localparam int HP  = 16;
    localparam int VP  = 10;
    localparam int HS  = 4;
    localparam int VS  = 3;
    localparam int CB  = 4;
    localparam int DEP = 16;
    localparam int BPF = (HP - HS) * (VP - VS) * 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          RST;
    logic          PEN;
    logic [9:0]    HCNT;
    logic [9:0]    VCNT;
    logic [CB-1:0] vr, vg, vb;
    logic          START;
    logic          OUT_READY;
    logic [7:0]    od  [2];
    logic          ov  [2];
    logic          bsy [2];
    logic          dn  [2];
    logic          of  [2];

    pix_capture #(
        .HPERIOD(HP), .VPERIOD(VP), .HSTART(HS), .VSTART(VS),
        .CBITS(CB), .NFRAMES(1), .DEPTH(DEP)
    ) u_dut1 (
        .CLK(clk), .RST(RST), .PEN(PEN), .HCNT(HCNT), .VCNT(VCNT),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .START(START),
        .OUT_DATA(od[0]), .OUT_VALID(ov[0]), .OUT_READY(OUT_READY),
        .BUSY(bsy[0]), .DONE(dn[0]), .OVERFLOW(of[0])
    );

    pix_capture #(
        .HPERIOD(HP), .VPERIOD(VP), .HSTART(HS), .VSTART(VS),
        .CBITS(CB), .NFRAMES(2), .DEPTH(DEP)
    ) u_dut2 (
        .CLK(clk), .RST(RST), .PEN(PEN), .HCNT(HCNT), .VCNT(VCNT),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .START(START),
        .OUT_DATA(od[1]), .OUT_VALID(ov[1]), .OUT_READY(OUT_READY),
        .BUSY(bsy[1]), .DONE(dn[1]), .OVERFLOW(of[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // test controls
    bit rst_req = 1'b1;
    bit gen_en, ready_bp, const_col, strict;
    int start_cnt = 0;

    // generator and reference model state
    int start_seen = 0;
    int hc, vc, pen_ph, rdy_ph;
    int m_st [2];
    int m_fr [2];
    int nf [2] = '{1, 2};
    int first_push [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    // monitor state
    int nbytes [2];
    int ndone [2];
    int first_valid [2];
    logic [7:0] first_byte [2];
    int tri_n [2];
    logic [7:0] tri_b [2][3];
    int prev_key [2];
    bit stall_q [2];
    logic [7:0] stall_d [2];
    logic [7:0] eb;
    int mr, mg, mb, key;
    bit ok;

    function automatic logic [7:0] ex(input logic [3:0] c);
`ifdef PIX_CAPTURE_REPLICATE_EN
        return {c, c};
`else
        return {c, 4'h0};
`endif
    endfunction

    function automatic logic [11:0] colour(input int h, input int v);
        logic [3:0] r, g, b;
        r = 4'(h);
        g = 4'(v);
        b = 4'(h + 2 * v);
        if (const_col) return 12'hA53;
        return {r, g, b};
    endfunction

    // drives every DUT input at posedge+1 and keeps the expected stream
    initial begin
        RST = 1'b1; PEN = 1'b0; HCNT = '0; VCNT = '0;
        vr = '0; vg = '0; vb = '0; START = 1'b0; OUT_READY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            RST = rst_req;
            START = (start_cnt != start_seen) && !rst_req;
            start_seen = start_cnt;
            OUT_READY = ready_bp ? (rdy_ph == 0) : 1'b1;
            rdy_ph = (rdy_ph + 1) % 3;
            PEN = 1'b0;
            if (rst_req) begin
                hc = 0; vc = 0; pen_ph = 0;
                for (int k = 0; k < 2; k++) begin
                    m_st[k] = 0; m_fr[k] = 0; first_push[k] = -1;
                end
                q0.delete();
                q1.delete();
            end else if (gen_en) begin
                {vr, vg, vb} = colour(hc, vc);
                HCNT = 10'(hc);
                VCNT = 10'(vc);
                PEN = (pen_ph == 0);
                pen_ph = (pen_ph + 1) % 4;
                if (PEN) begin
                    for (int k = 0; k < 2; k++) begin
                        if (m_st[k] == 1 && hc == 0 && vc == 0) begin
                            m_st[k] = 2;
                        end else if (m_st[k] == 2) begin
                            if (hc >= HS && vc >= VS) begin
                                if (first_push[k] < 0) first_push[k] = cyc;
                                if (strict && k == 0) begin
                                    q0.push_back(ex(vr));
                                    q0.push_back(ex(vg));
                                    q0.push_back(ex(vb));
                                end
                                if (strict && k == 1) begin
                                    q1.push_back(ex(vr));
                                    q1.push_back(ex(vg));
                                    q1.push_back(ex(vb));
                                end
                            end
                            if (hc == HP - 1 && vc == VP - 1) begin
                                m_fr[k]++;
                                if (m_fr[k] == nf[k]) m_st[k] = 3;
                            end
                        end
                    end
                    hc++;
                    if (hc == HP) begin
                        hc = 0;
                        vc = (vc + 1) % VP;
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (START && m_st[k] == 0) begin
                    m_st[k] = 1;
                    m_fr[k] = 0;
                end
            end
        end
    end

    // samples outputs at negedge, pops scoreboard on each transfer
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (RST) begin
                    nbytes[k] = 0; ndone[k] = 0; first_valid[k] = -1;
                    first_byte[k] = 8'h00; tri_n[k] = 0;
                    prev_key[k] = -1; stall_q[k] = 1'b0;
                end else begin
                    if (stall_q[k]) begin
                        tests++;
                        if (ov[k] !== 1'b1 || od[k] !== stall_d[k]) begin
                            fails++;
                            $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=%h",
                                     k, ov[k], od[k], stall_d[k]);
                        end
                    end
                    stall_q[k] = ov[k] && !OUT_READY;
                    stall_d[k] = od[k];
                    if (ov[k] && first_valid[k] < 0) begin
                        first_valid[k] = cyc;
                        first_byte[k] = od[k];
                    end
                    if (ov[k] && OUT_READY) begin
                        nbytes[k]++;
                        if (strict) begin
                            tests++;
                            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                                fails++;
                                $display("FAIL extra_byte[%0d]: got %h want none",
                                         k, od[k]);
                            end else begin
                                eb = (k == 0) ? q0.pop_front() : q1.pop_front();
                                if (od[k] !== eb) begin
                                    fails++;
                                    $display("FAIL byte[%0d] #%0d: got %h want %h",
                                             k, nbytes[k], od[k], eb);
                                end
                            end
                        end else begin
                            tri_b[k][tri_n[k]] = od[k];
                            tri_n[k]++;
                            if (tri_n[k] == 3) begin
                                tri_n[k] = 0;
                                tests++;
                                mr = int'(tri_b[k][0][7:4]);
                                mg = int'(tri_b[k][1][7:4]);
                                mb = int'(tri_b[k][2][7:4]);
                                key = mg * 16 + mr;
                                ok = tri_b[k][0] == ex(4'(mr))
                                  && tri_b[k][1] == ex(4'(mg))
                                  && tri_b[k][2] == ex(4'(mb))
                                  && mr >= HS && mg >= VS && mg < VP
                                  && mb == (mr + 2 * mg) % 16;
                                if (k == 0 && key <= prev_key[0]) ok = 1'b0;
                                prev_key[k] = key;
                                if (!ok) begin
                                    fails++;
                                    $display("FAIL triplet[%0d]: got %h %h %h want ordered pixel",
                                             k, tri_b[k][0], tri_b[k][1], tri_b[k][2]);
                                end
                            end
                        end
                    end
                    if (dn[k] === 1'b1) begin
                        ndone[k]++;
                        tests++;
                        if (!(ov[k] && OUT_READY)
                            || (strict && (k == 0 ? q0.size() : q1.size()) != 0)) begin
                            fails++;
                            $display("FAIL done_align[%0d]: got xfer=%b want final transfer",
                                     k, ov[k] && OUT_READY);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_req = 1'b1;
        gen_en = 1'b0;
        ready_bp = 1'b0;
        repeat (3) @(posedge clk);
        rst_req = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (ndone[0] > 0 && ndone[1] > 0 && !bsy[0] && !bsy[1]) break;
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_req = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (ov[k] !== 1'b0 || bsy[k] !== 1'b0 || dn[k] !== 1'b0
                || of[k] !== 1'b0 || od[k] !== 8'h00) begin
                fails++;
                $display("FAIL reset[%0d]: got v=%b b=%b d=%b o=%b data=%h want all 0",
                         k, ov[k], bsy[k], dn[k], of[k], od[k]);
            end
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        do_reset();
        const_col = 1'b1;
        strict = 1'b1;
        gen_en = 1'b1;
        start_cnt++;
        wait_done(4000);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (ndone[k] !== 1 || nbytes[k] !== nf[k] * BPF) begin
                fails++;
                $display("FAIL frame_count[%0d]: got done=%0d bytes=%0d want 1/%0d",
                         k, ndone[k], nbytes[k], nf[k] * BPF);
            end
            tests++;
            if (of[k] !== 1'b0 || bsy[k] !== 1'b0) begin
                fails++;
                $display("FAIL frame_flags[%0d]: got ovf=%b busy=%b want 0/0",
                         k, of[k], bsy[k]);
            end
        end
        tests++;
        if (first_byte[0] !== ex(4'hA)) begin
            fails++;
            $display("FAIL const_first: got %h want %h", first_byte[0], ex(4'hA));
        end
        tests++;
        if (first_valid[0] - first_push[0] !== 2) begin
            fails++;
            $display("FAIL latency: got %0d want 2", first_valid[0] - first_push[0]);
        end
    endtask

    task automatic test_midframe();
        do_reset();
        const_col = 1'b0;
        strict = 1'b1;
        gen_en = 1'b1;
        for (int i = 0; i < 2000 && vc != 5; i++) @(posedge clk);
        start_cnt++;
        wait_done(4000);
        tests++;
        if (first_byte[0] !== ex(4'(HS))) begin
            fails++;
            $display("FAIL mid_first: got %h want %h", first_byte[0], ex(4'(HS)));
        end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (ndone[k] !== 1 || nbytes[k] !== nf[k] * BPF) begin
                fails++;
                $display("FAIL mid_count[%0d]: got done=%0d bytes=%0d want 1/%0d",
                         k, ndone[k], nbytes[k], nf[k] * BPF);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        const_col = 1'b0;
        strict = 1'b1;
        gen_en = 1'b1;
        start_cnt++;
        for (int i = 0; i < 2000 && !(m_st[1] == 2 && vc == 5); i++) @(posedge clk);
        start_cnt++;
        wait_done(4000);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (ndone[k] !== 1 || nbytes[k] !== nf[k] * BPF) begin
                fails++;
                $display("FAIL restart_ign[%0d]: got done=%0d bytes=%0d want 1/%0d",
                         k, ndone[k], nbytes[k], nf[k] * BPF);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        const_col = 1'b0;
        strict = 1'b0;
        ready_bp = 1'b1;
        gen_en = 1'b1;
        start_cnt++;
        wait_done(8000);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (of[k] !== 1'b1) begin
                fails++;
                $display("FAIL ovf_set[%0d]: got %b want 1", k, of[k]);
            end
            tests++;
            if (ndone[k] !== 1 || nbytes[k] % 3 != 0 || nbytes[k] == 0) begin
                fails++;
                $display("FAIL bp_count[%0d]: got done=%0d bytes=%0d want 1/mult of 3",
                         k, ndone[k], nbytes[k]);
            end
        end
        start_cnt++;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (of[k] !== 1'b0 || bsy[k] !== 1'b1) begin
                fails++;
                $display("FAIL ovf_clear[%0d]: got ovf=%b busy=%b want 0/1",
                         k, of[k], bsy[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        const_col = 1'b0;
        strict = 1'b1;
        gen_en = 1'b1;
        start_cnt++;
        for (int i = 0; i < 3000 && nbytes[0] < 30; i++) @(posedge clk);
        rst_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (ov[k] !== 1'b0 || bsy[k] !== 1'b0 || dn[k] !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid[%0d]: got v=%b b=%b d=%b want 0/0/0",
                         k, ov[k], bsy[k], dn[k]);
            end
        end
        rst_req = 1'b0;
        gen_en = 1'b1;
        repeat (800) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (ndone[k] !== 0 || nbytes[k] !== 0 || bsy[k] !== 1'b0) begin
                fails++;
                $display("FAIL rst_quiet[%0d]: got done=%0d bytes=%0d busy=%b want 0/0/0",
                         k, ndone[k], nbytes[k], bsy[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_midframe();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
